doorlock_supervisor: RTL

- Sequences the switch-code detector that sits in front of it.
- Consumes the detector's pass/fail indications and decides what happens next:
  - drives the door-unlock strobe for a fixed time;
  - counts consecutive failed attempts;
  - enforces a lockout period after too many failures, holding the detector in reset.
- Sits between the detector and the door actuator / status LEDs.

---
 rtl/doorlock_pkg.sv | 14 +
 rtl/doorlock_edge_det.sv | 23 ++
 rtl/doorlock_supervisor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/doorlock_pkg.sv
// Shared types and default timing constants for the door-lock supervisor slice.
package doorlock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam int unsigned DEF_UNLOCK_CYCLES  = 8;
    localparam int unsigned DEF_MAX_FAILS      = 3;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 16;

endpackage

// File: rtl/doorlock_edge_det.sv
// 1-bit rising-edge detector: a held level yields a single one-cycle event.
module doorlock_edge_det (
    input  logic clk,
    input  logic clr,
    input  logic d_i,
    output logic ev_o
);

    logic d_q, d_d;

    always_comb d_d = d_i;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign ev_o = d_i & ~d_q;

endmodule

// File: rtl/doorlock_supervisor.sv
// Door-lock supervisor: timed unlock, consecutive-fail counting and lockout.
// Optional latched alarm enabled by defining DOORLOCK_SUPERVISOR_ALARM_EN.
module doorlock_supervisor
    import doorlock_pkg::*;
#(
    parameter int unsigned UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int unsigned MAX_FAILS      = DEF_MAX_FAILS,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned TMR_W          = 8
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           pass_in,
    input  logic                           fail_in,
    input  logic                           relock,
    output logic                           unlock,
    output logic                           locked_out,
    output logic                           det_clr,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt,
    output logic                           alarm
);

    localparam int unsigned FCW = $clog2(MAX_FAILS + 1);
    localparam logic [TMR_W-1:0] TMR_UNLOCK  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOCKOUT = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [FCW-1:0]   fail_cnt_q, fail_cnt_d;
    logic             pass_ev, fail_ev;

    doorlock_edge_det u_pass_edge (
        .clk  (clk),
        .clr  (clr),
        .d_i  (pass_in),
        .ev_o (pass_ev)
    );

    doorlock_edge_det u_fail_edge (
        .clk  (clk),
        .clr  (clr),
        .d_i  (fail_in),
        .ev_o (fail_ev)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        case (state_q)
            IDLE: begin
                // A simultaneous pass and fail is resolved as a fail.
                if (fail_ev) begin
                    if (32'(fail_cnt_q) + 32'd1 == MAX_FAILS) begin
                        state_d    = LOCKOUT;
                        timer_d    = TMR_LOCKOUT;
                        fail_cnt_d = '0;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FCW'(1);
                    end
                end else if (pass_ev) begin
                    state_d    = OPEN;
                    timer_d    = TMR_UNLOCK;
                    fail_cnt_d = '0;
                end
            end
            OPEN: begin
                if (relock) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (pass_ev) begin
                    timer_d = TMR_UNLOCK;
                end else if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                timer_d    = '0;
                fail_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    always_comb begin
        unlock     = 1'b0;
        locked_out = 1'b0;
        det_clr    = 1'b0;
        case (state_q)
            OPEN:    unlock = 1'b1;
            LOCKOUT: begin
                locked_out = 1'b1;
                det_clr    = 1'b1;
            end
            default: ;
        endcase
    end

    assign fail_cnt = fail_cnt_q;

`ifdef DOORLOCK_SUPERVISOR_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_q;
        if (state_q == IDLE && state_d == LOCKOUT) begin
            alarm_d = 1'b1;
        end else if (state_q == IDLE && state_d == OPEN) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    assign alarm = 1'b0;
`endif

endmodule
